// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider. Each channel produces a divided waveform
// and period tick; new period/high settings are shadowed and applied on a period boundary.
module clock_divider_multi #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 24,
    parameter int DEFAULT_DIV  = 2,
    parameter int DEFAULT_HIGH = 1,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic [CNT_W-1:0]  wr_high,
    input  logic              restart,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [CNT_W-1:0] DEF_P = (DEFAULT_DIV < 2) ? CNT_W'(2) : CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEFAULT_HIGH);

    typedef enum logic {
        CH_IDLE,
        CH_RUN
    } chState_t;

    chState_t          r_state [NUM_CH];
    logic [CNT_W-1:0]  r_cnt   [NUM_CH];
    logic [CNT_W-1:0]  r_pAct  [NUM_CH];
    logic [CNT_W-1:0]  r_hAct  [NUM_CH];
    logic [CNT_W-1:0]  r_pSh   [NUM_CH];
    logic [CNT_W-1:0]  r_hSh   [NUM_CH];
    logic [NUM_CH-1:0] r_clkOut;
    logic [NUM_CH-1:0] r_tick;
    logic [NUM_CH-1:0] r_pending;

    chState_t          w_stateNext [NUM_CH];
    logic [CNT_W-1:0]  w_cntNext   [NUM_CH];
    logic [CNT_W-1:0]  w_pActNext  [NUM_CH];
    logic [CNT_W-1:0]  w_hActNext  [NUM_CH];
    logic [CNT_W-1:0]  w_pShNext   [NUM_CH];
    logic [CNT_W-1:0]  w_hShNext   [NUM_CH];
    logic [CNT_W-1:0]  w_cntInc    [NUM_CH];
    logic [NUM_CH-1:0] w_clkNext;
    logic [NUM_CH-1:0] w_tickNext;
    logic [NUM_CH-1:0] w_pendNext;
    logic [NUM_CH-1:0] w_wrHit;
    logic [NUM_CH-1:0] w_atEnd;

    logic              w_wrValid;
    logic [CNT_W-1:0]  w_wrDivClamped;

    // A period shorter than two cycles cannot show both levels, so it is stored as 2.
    assign w_wrValid      = wr_en && (int'(wr_ch) < NUM_CH);
    assign w_wrDivClamped = (wr_div < CNT_W'(2)) ? CNT_W'(2) : wr_div;

    // The shadow always follows a write; which boundary copies it into the active set
    // is decided below, so a write on a boundary edge lands in the active set directly.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_wrHit[c]   = w_wrValid && (wr_ch == CH_W'(c));
            w_pShNext[c] = w_wrHit[c] ? w_wrDivClamped : r_pSh[c];
            w_hShNext[c] = w_wrHit[c] ? wr_high : r_hSh[c];
            w_cntInc[c]  = r_cnt[c] + CNT_W'(1);
            w_atEnd[c]   = (r_cnt[c] == (r_pAct[c] - CNT_W'(1)));
        end
    end

    always_comb begin
        w_clkNext  = r_clkOut;
        w_tickNext = '0;
        w_pendNext = r_pending;
        for (int c = 0; c < NUM_CH; c++) begin
            w_stateNext[c] = r_state[c];
            w_cntNext[c]   = r_cnt[c];
            w_pActNext[c]  = r_pAct[c];
            w_hActNext[c]  = r_hAct[c];

            if (!en[c]) begin
                w_stateNext[c] = CH_IDLE;
                w_cntNext[c]   = '0;
                w_clkNext[c]   = 1'b0;
                w_tickNext[c]  = 1'b0;
                w_pActNext[c]  = w_pShNext[c];
                w_hActNext[c]  = w_hShNext[c];
                w_pendNext[c]  = 1'b0;
            end else if ((r_state[c] == CH_IDLE) || restart || w_atEnd[c]) begin
                // Start, forced restart and natural wrap all begin a fresh period.
                w_stateNext[c] = CH_RUN;
                w_cntNext[c]   = '0;
                w_tickNext[c]  = 1'b1;
                w_pActNext[c]  = w_pShNext[c];
                w_hActNext[c]  = w_hShNext[c];
                w_clkNext[c]   = (w_hShNext[c] != '0);
                w_pendNext[c]  = 1'b0;
            end else begin
                w_cntNext[c]   = w_cntInc[c];
                w_clkNext[c]   = (w_cntInc[c] < r_hAct[c]);
                w_tickNext[c]  = 1'b0;
                w_pendNext[c]  = r_pending[c] | w_wrHit[c];
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= CH_IDLE;
                r_cnt[c]   <= '0;
                r_pAct[c]  <= DEF_P;
                r_hAct[c]  <= DEF_H;
                r_pSh[c]   <= DEF_P;
                r_hSh[c]   <= DEF_H;
            end
            r_clkOut  <= '0;
            r_tick    <= '0;
            r_pending <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= w_stateNext[c];
                r_cnt[c]   <= w_cntNext[c];
                r_pAct[c]  <= w_pActNext[c];
                r_hAct[c]  <= w_hActNext[c];
                r_pSh[c]   <= w_pShNext[c];
                r_hSh[c]   <= w_hShNext[c];
            end
            r_clkOut  <= w_clkNext;
            r_tick    <= w_tickNext;
            r_pending <= w_pendNext;
        end
    end

    assign clk_out = r_clkOut;
    assign tick    = r_tick;
    assign pending = r_pending;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: fixed vector table, directed corner sequences and
// randomized traffic compared against a period-position reference model.
module tb_clock_divider_multi;

    localparam int NCH = 3;
    localparam int CW  = 8;

    logic           clock_in = 1'b0;
    logic           reset_n;
    logic [NCH-1:0] en;
    logic           wr_en;
    logic [1:0]     wr_ch;
    logic [CW-1:0]  wr_div;
    logic [CW-1:0]  wr_high;
    logic           restart;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pending;

    always #5 clock_in = ~clock_in;

    clock_divider_multi #(
        .NUM_CH(NCH),
        .CNT_W(CW),
        .DEFAULT_DIV(2),
        .DEFAULT_HIGH(1)
    ) dut (
        .clock_in(clock_in),
        .reset_n(reset_n),
        .en(en),
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_div(wr_div),
        .wr_high(wr_high),
        .restart(restart),
        .clk_out(clk_out),
        .tick(tick),
        .pending(pending)
    );

    int nChecks = 0;
    int nFails  = 0;
    int cycle   = 0;

    // Reference model: position inside the current period plus active/shadow settings.
    int             mP    [NCH];
    int             mH    [NCH];
    int             mShP  [NCH];
    int             mShH  [NCH];
    int             mPos  [NCH];
    bit             mRun  [NCH];
    logic [NCH-1:0] expClk;
    logic [NCH-1:0] expTick;
    logic [NCH-1:0] expPend;

    typedef struct {
        logic [NCH-1:0] en;
        logic           we;
        logic [1:0]     wc;
        logic [CW-1:0]  wd;
        logic [CW-1:0]  wh;
        logic [NCH-1:0] clk;
        logic [NCH-1:0] tk;
        logic [NCH-1:0] pd;
    } vec_t;

    vec_t vecs [15];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < NCH; c++) begin
            mP[c]   = 2;
            mH[c]   = 1;
            mShP[c] = 2;
            mShH[c] = 1;
            mPos[c] = 0;
            mRun[c] = 1'b0;
        end
        expClk  = '0;
        expTick = '0;
        expPend = '0;
    endtask

    task automatic modelStep(input logic [NCH-1:0] e, input logic we, input logic [1:0] wc,
                             input logic [CW-1:0] wd, input logic [CW-1:0] wh, input logic rs);
        bit hit;
        bit boundary;
        for (int c = 0; c < NCH; c++) begin
            hit = we && (int'(wc) == c);
            if (hit) begin
                mShP[c] = (int'(wd) < 2) ? 2 : int'(wd);
                mShH[c] = int'(wh);
            end
            if (!e[c]) begin
                mRun[c]    = 1'b0;
                mP[c]      = mShP[c];
                mH[c]      = mShH[c];
                mPos[c]    = 0;
                expPend[c] = 1'b0;
                expClk[c]  = 1'b0;
                expTick[c] = 1'b0;
            end else begin
                boundary = !mRun[c] || rs || (((mPos[c] + 1) % mP[c]) == 0);
                if (boundary) begin
                    mP[c]      = mShP[c];
                    mH[c]      = mShH[c];
                    mPos[c]    = 0;
                    mRun[c]    = 1'b1;
                    expPend[c] = 1'b0;
                end else begin
                    mPos[c] = mPos[c] + 1;
                    if (hit) expPend[c] = 1'b1;
                end
                expTick[c] = boundary;
                expClk[c]  = (mPos[c] < mH[c]);
            end
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] e, input logic we, input logic [1:0] wc,
                                 input logic [CW-1:0] wd, input logic [CW-1:0] wh, input logic rs);
        en      = e;
        wr_en   = we;
        wr_ch   = wc;
        wr_div  = wd;
        wr_high = wh;
        restart = rs;
        @(posedge clock_in);
        modelStep(e, we, wc, wd, wh, rs);
        cycle++;
        #1;
        checkOutput("clk_out", 32'(clk_out), 32'(expClk));
        checkOutput("tick", 32'(tick), 32'(expTick));
        checkOutput("pending", 32'(pending), 32'(expPend));
    endtask

    task automatic run(input logic [NCH-1:0] e);
        applyStimulus(e, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nT;
        int nH;
        int gap;

        // Defaults, then ch1 P=5 H=2 while disabled, then a mid-period rewrite to P=3 H=1.
        vecs[0]  = '{3'b000, 1'b1, 2'd1, 8'd5, 8'd2, 3'b000, 3'b000, 3'b000};
        vecs[1]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b011, 3'b011, 3'b000};
        vecs[2]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b010, 3'b000, 3'b000};
        vecs[3]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b001, 3'b000};
        vecs[4]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000};
        vecs[5]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b001, 3'b000};
        vecs[6]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b010, 3'b010, 3'b000};
        vecs[7]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b011, 3'b001, 3'b000};
        vecs[8]  = '{3'b011, 1'b1, 2'd1, 8'd3, 8'd1, 3'b000, 3'b000, 3'b010};
        vecs[9]  = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b001, 3'b010};
        vecs[10] = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b010};
        vecs[11] = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b011, 3'b011, 3'b000};
        vecs[12] = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000};
        vecs[13] = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b001, 3'b000};
        vecs[14] = '{3'b011, 1'b0, 2'd0, 8'd0, 8'd0, 3'b010, 3'b010, 3'b000};

        reset_n = 1'b0;
        en      = '0;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_div  = '0;
        wr_high = '0;
        restart = 1'b0;
        modelReset();
        repeat (2) @(posedge clock_in);
        #1;
        checkOutput("reset_clk_out", 32'(clk_out), 32'd0);
        checkOutput("reset_tick", 32'(tick), 32'd0);
        checkOutput("reset_pending", 32'(pending), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].en, vecs[i].we, vecs[i].wc, vecs[i].wd, vecs[i].wh, 1'b0);
            checkOutput($sformatf("vec%0d_clk", i), 32'(clk_out), 32'(vecs[i].clk));
            checkOutput($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].tk));
            checkOutput($sformatf("vec%0d_pend", i), 32'(pending), 32'(vecs[i].pd));
        end

        // ch2 P=4 H=0: flat low, ticks still every 4 cycles.
        applyStimulus(3'b000, 1'b1, 2'd2, 8'd4, 8'd0, 1'b0);
        nT = 0;
        nH = 0;
        for (int i = 0; i < 8; i++) begin
            run(3'b100);
            nT += int'(tick[2]);
            nH += int'(clk_out[2]);
        end
        checkOutput("h0_ticks", 32'(nT), 32'd2);
        checkOutput("h0_highs", 32'(nH), 32'd0);

        // H=7 written on the wrap edge goes straight to the active set: flat high.
        nT = 0;
        nH = 0;
        applyStimulus(3'b100, 1'b1, 2'd2, 8'd4, 8'd7, 1'b0);
        nT += int'(tick[2]);
        nH += int'(clk_out[2]);
        for (int i = 0; i < 7; i++) begin
            run(3'b100);
            nT += int'(tick[2]);
            nH += int'(clk_out[2]);
        end
        checkOutput("h7_ticks", 32'(nT), 32'd2);
        checkOutput("h7_highs", 32'(nH), 32'd8);

        // P=1 is stored as 2.
        applyStimulus(3'b000, 1'b1, 2'd2, 8'd1, 8'd1, 1'b0);
        run(3'b100);
        checkOutput("p1_start_tick", 32'(tick[2]), 32'd1);
        gap = 0;
        for (int i = 1; i <= 10; i++) begin
            run(3'b100);
            if (tick[2]) begin
                gap = i;
                break;
            end
        end
        checkOutput("p1_period", 32'(gap), 32'd2);

        // ch0 P=4 and ch2 P=6 out of phase, then restart realigns them.
        applyStimulus(3'b000, 1'b1, 2'd0, 8'd4, 8'd2, 1'b0);
        applyStimulus(3'b000, 1'b1, 2'd2, 8'd6, 8'd3, 1'b0);
        run(3'b001);
        run(3'b001);
        run(3'b001);
        for (int i = 0; i < 4; i++) run(3'b101);
        applyStimulus(3'b101, 1'b0, 2'd0, 8'd0, 8'd0, 1'b1);
        checkOutput("restart_align", 32'({tick[2], tick[0]}), 32'd3);
        gap = 0;
        for (int i = 1; i <= 20; i++) begin
            run(3'b101);
            if (tick[0] && tick[2]) begin
                gap = i;
                break;
            end
        end
        checkOutput("realign_period", 32'(gap), 32'd12);

        // Pending write on ch0 mid-period, then asynchronous reset between edges.
        applyStimulus(3'b101, 1'b1, 2'd0, 8'd9, 8'd4, 1'b0);
        checkOutput("pending_set", 32'(pending[0]), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_clk_out", 32'(clk_out), 32'd0);
        checkOutput("async_rst_tick", 32'(tick), 32'd0);
        checkOutput("async_rst_pending", 32'(pending), 32'd0);
        en      = '0;
        wr_en   = 1'b0;
        restart = 1'b0;
        modelReset();
        @(posedge clock_in);
        #1;
        reset_n = 1'b1;

        // Write to a nonexistent channel is dropped; ch0 runs with defaults.
        applyStimulus(3'b001, 1'b1, 2'd3, 8'd7, 8'd3, 1'b0);
        checkOutput("ignored_wr_pending", 32'(pending), 32'd0);
        checkOutput("post_reset_start", 32'({clk_out[0], tick[0]}), 32'd3);
        nH = 0;
        for (int i = 0; i < 6; i++) begin
            run(3'b001);
            nH += int'(clk_out[0]);
        end
        checkOutput("default_highs", 32'(nH), 32'd3);

        for (int i = 0; i < 400; i++) begin
            logic [NCH-1:0] e;
            for (int c = 0; c < NCH; c++) e[c] = ($urandom_range(0, 9) != 0);
            applyStimulus(e,
                          ($urandom_range(0, 5) == 0),
                          2'($urandom_range(0, 3)),
                          8'($urandom_range(0, 10)),
                          8'($urandom_range(0, 11)),
                          ($urandom_range(0, 29) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
